tm1638_stimulus_select: RTL

//  Parametrised N-channel frame selector between stimulus/frame sources and tm1638_driver.

---
 rtl/tm1638_stimulus_select.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tm1638_stimulus_select.sv
// tm1638_stimulus_select: N-channel frame selector feeding the tm1638 driver.
// Every channel's latest frame is held. One channel is selected, either by
// next/prev pulses or by a rotation timer, and its frame is offered downstream
// on a valid/ready handshake. A pending frame that is overwritten or discarded
// before acceptance increments a saturating drop counter.

// Per-channel hold register: the latest frame and a flag saying one has arrived.
module tm1638_hold_lane #(
   parameter int DATA_W = 72
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_hold,
   output logic              o_seen
);
   logic [DATA_W-1:0] hold_d, hold_q;
   logic              seen_d, seen_q;

   // Capture every valid frame, whether or not this channel is selected.
   always_comb begin
      hold_d = hold_q;
      seen_d = seen_q;
      if (i_valid) begin
         hold_d = i_data;
         seen_d = 1'b1;
      end
   end

   // Hold state, cleared on reset so an old frame is never replayed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q <= '0;
         seen_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         seen_q <= seen_d;
      end
   end

   assign o_hold = hold_q;
   assign o_seen = seen_q;
endmodule

module tm1638_stimulus_select #(
   parameter  int NUM_CH      = 8,
   parameter  int DATA_W      = 72,
   parameter  int AUTO_CYCLES = 5_400_000,
   localparam int SEL_W       = $clog2(NUM_CH)
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_n,
   input  logic                     i_Mode,
   input  logic                     i_Next,
   input  logic                     i_Prev,
   input  logic [NUM_CH*DATA_W-1:0] i_Data,
   input  logic [NUM_CH-1:0]        i_Valid,
   output logic [DATA_W-1:0]        o_Data,
   output logic                     o_Valid,
   input  logic                     i_Ready,
   output logic [SEL_W-1:0]         o_Sel,
   output logic                     o_Sel_Changed,
   output logic [15:0]              o_Drop_Count
);
   localparam int TMR_W = $clog2(AUTO_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

   logic [NUM_CH-1:0][DATA_W-1:0] in_data;
   logic [NUM_CH-1:0][DATA_W-1:0] hold;
   logic [NUM_CH-1:0]             seen;

   logic [DATA_W-1:0] data_d, data_q;
   logic              valid_d, valid_q;
   logic [SEL_W-1:0]  sel_d, sel_q;
   logic              sel_chg_d, sel_chg_q;
   logic [15:0]       drop_d, drop_q;
   logic [TMR_W-1:0]  timer_d, timer_q;
   logic              mode_d, mode_q;

   logic              manual_step, auto_step, step;
   logic              load, discard, xfer;
   logic [DATA_W-1:0] load_data;
   logic [SEL_W-1:0]  sel_inc, sel_dec;

   assign in_data = i_Data;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tm1638_hold_lane #(.DATA_W(DATA_W)) u_lane (
         .i_clk   (i_Clk),
         .i_rst_n (i_Rst_n),
         .i_valid (i_Valid[k]),
         .i_data  (in_data[k]),
         .o_hold  (hold[k]),
         .o_seen  (seen[k])
      );
   end

   // Selection: pulses win over the timer; simultaneous next+prev cancel out.
   always_comb begin
      manual_step = i_Next ^ i_Prev;
      auto_step   = 1'b0;
      mode_d      = i_Mode;
      timer_d     = timer_q;
      if (!i_Mode || manual_step || (i_Mode != mode_q)) begin
         timer_d = '0;
      end else if (timer_q == TMR_LAST) begin
         timer_d   = '0;
         auto_step = 1'b1;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end
      step    = manual_step | auto_step;
      sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      sel_dec = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
      sel_d   = sel_q;
      if (manual_step && i_Prev) sel_d = sel_dec;
      else if (step)             sel_d = sel_inc;
      sel_chg_d = step;
   end

   // Output frame: a step re-emits the new channel's frame (live beats held);
   // stepping to a channel that never sent anything drops the pending frame.
   always_comb begin
      load      = 1'b0;
      discard   = 1'b0;
      load_data = in_data[sel_d];
      if (step) begin
         if (i_Valid[sel_d]) begin
            load = 1'b1;
         end else if (seen[sel_d]) begin
            load      = 1'b1;
            load_data = hold[sel_d];
         end else begin
            discard = 1'b1;
         end
      end else if (i_Valid[sel_q]) begin
         load = 1'b1;
      end
      xfer    = valid_q & i_Ready;
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end else if (discard || xfer) begin
         valid_d = 1'b0;
      end
      drop_d = drop_q;
      if (valid_q && !i_Ready && (load || discard) && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
   end

   // All outputs are registered so an async reset clears them at once.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         sel_q     <= '0;
         sel_chg_q <= 1'b0;
         drop_q    <= '0;
         timer_q   <= '0;
         mode_q    <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         sel_q     <= sel_d;
         sel_chg_q <= sel_chg_d;
         drop_q    <= drop_d;
         timer_q   <= timer_d;
         mode_q    <= mode_d;
      end
   end

   assign o_Data        = data_q;
   assign o_Valid       = valid_q;
   assign o_Sel         = sel_q;
   assign o_Sel_Changed = sel_chg_q;
   assign o_Drop_Count  = drop_q;
endmodule
